sdcard_cmd_responder: RTL and testbench

//  Card-side engine for the SD command line: the responder for the SD host in sdcard_top.

---
 rtl/sdcard_cmd_responder_if.sv | 28 ++
 rtl/sdcard_cmd_responder.sv | 197 +++++++++++++++++++
 tb/tb_sdcard_cmd_responder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_cmd_responder_if.sv
// Signal bundle between the SD command-line responder and its card model / host-side pins.
// The responder takes the slave view; benches and card models take the master view.
interface sdcard_cmd_responder_if;
    logic        sd_clk;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_none;
    logic [5:0]  rsp_idx;
    logic [31:0] rsp_arg;
    logic        rsp_nocrc;
    logic        crc_err;
    logic        busy;

    modport slave (
        input  sd_clk, cmd_in, rsp_valid, rsp_none, rsp_idx, rsp_arg, rsp_nocrc,
        output cmd_out, cmd_oe, cmd_valid, cmd_idx, cmd_arg, crc_err, busy
    );

    modport master (
        output sd_clk, cmd_in, rsp_valid, rsp_none, rsp_idx, rsp_arg, rsp_nocrc,
        input  cmd_out, cmd_oe, cmd_valid, cmd_idx, cmd_arg, crc_err, busy
    );
endinterface

// File: rtl/sdcard_cmd_responder.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, checks framing and CRC7,
// and returns a 48-bit short response NCR SD_CLK cycles after the command end bit.
module sdcard_cmd_responder #(
    parameter int NCR      = 2,
    parameter int SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sdcard_cmd_responder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_WAIT_RSP,
        ST_NCR,
        ST_TX
    } state_t;

    localparam logic [6:0] NCR_L = 7'(NCR);

    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    state_t              state_q, state_d;
    logic [SYNC_STG-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0] cmd_sync_q, cmd_sync_d;
    logic                sclk_prev_q, sclk_prev_d;
    logic [47:0]         rx_sr_q, rx_sr_d;
    logic [5:0]          rx_cnt_q, rx_cnt_d;
    logic [6:0]          ncr_cnt_q, ncr_cnt_d;
    logic [47:0]         tx_sr_q, tx_sr_d;
    logic [5:0]          tx_cnt_q, tx_cnt_d;
    logic                cmd_out_q, cmd_out_d;
    logic                cmd_oe_q, cmd_oe_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                crc_err_q, crc_err_d;
    logic [5:0]          cmd_idx_q, cmd_idx_d;
    logic [31:0]         cmd_arg_q, cmd_arg_d;

    logic       sclk_s;
    logic       cmd_s;
    logic       s_strobe;
    logic       d_strobe;
    logic [6:0] ncr_inc;
    logic [6:0] rx_crc;
    logic [6:0] rsp_crc;

    assign sclk_s   = sclk_sync_q[SYNC_STG-1];
    assign cmd_s    = cmd_sync_q[SYNC_STG-1];
    assign s_strobe = sclk_s & ~sclk_prev_q;
    assign d_strobe = ~sclk_s & sclk_prev_q;
    assign ncr_inc  = (ncr_cnt_q >= NCR_L) ? ncr_cnt_q : ncr_cnt_q + 7'd1;
    assign rx_crc   = crc7(rx_sr_q[47:8]);
    assign rsp_crc  = crc7({2'b00, bus.rsp_idx, bus.rsp_arg});

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], bus.sd_clk};
        cmd_sync_d  = {cmd_sync_q[SYNC_STG-2:0], bus.cmd_in};
        sclk_prev_d = sclk_s;
        rx_sr_d     = rx_sr_q;
        rx_cnt_d    = rx_cnt_q;
        ncr_cnt_d   = ncr_cnt_q;
        tx_sr_d     = tx_sr_q;
        tx_cnt_d    = tx_cnt_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;
        cmd_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;

        // NCR counts drive strobes from the command end bit onward, saturating at NCR.
        if (d_strobe && (state_q == ST_CHECK || state_q == ST_WAIT_RSP || state_q == ST_NCR)) begin
            ncr_cnt_d = ncr_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (s_strobe && !cmd_s) begin
                    rx_sr_d  = {rx_sr_q[46:0], cmd_s};
                    rx_cnt_d = 6'd1;
                    state_d  = ST_RX;
                end
            end
            ST_RX: begin
                if (s_strobe) begin
                    rx_sr_d = {rx_sr_q[46:0], cmd_s};
                    if (rx_cnt_q == 6'd47) begin
                        ncr_cnt_d = 7'd0;
                        state_d   = ST_CHECK;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 6'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_sr_q[46] && rx_sr_q[0] && (rx_sr_q[7:1] == rx_crc)) begin
                    cmd_valid_d = 1'b1;
                    cmd_idx_d   = rx_sr_q[45:40];
                    cmd_arg_d   = rx_sr_q[39:8];
                    state_d     = ST_WAIT_RSP;
                end else begin
                    crc_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.rsp_none) begin
                    state_d = ST_IDLE;
                end else if (bus.rsp_valid) begin
                    tx_sr_d = {2'b00, bus.rsp_idx, bus.rsp_arg,
                               bus.rsp_nocrc ? 7'h7F : rsp_crc, 1'b1};
                    state_d = ST_NCR;
                end
            end
            ST_NCR: begin
                if (d_strobe && (ncr_inc >= NCR_L)) begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_sr_q[47];
                    tx_sr_d   = {tx_sr_q[46:0], 1'b1};
                    tx_cnt_d  = 6'd1;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                if (d_strobe) begin
                    if (tx_cnt_q == 6'd48) begin
                        cmd_oe_d  = 1'b0;
                        cmd_out_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cmd_out_d = tx_sr_q[47];
                        tx_sr_d   = {tx_sr_q[46:0], 1'b1};
                        tx_cnt_d  = tx_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cmd_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            rx_sr_q     <= '0;
            rx_cnt_q    <= '0;
            ncr_cnt_q   <= '0;
            tx_sr_q     <= '1;
            tx_cnt_q    <= '0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cmd_sync_q  <= cmd_sync_d;
            sclk_prev_q <= sclk_prev_d;
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            ncr_cnt_q   <= ncr_cnt_d;
            tx_sr_q     <= tx_sr_d;
            tx_cnt_q    <= tx_cnt_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    assign bus.cmd_out   = cmd_out_q;
    assign bus.cmd_oe    = cmd_oe_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.cmd_idx   = cmd_idx_q;
    assign bus.cmd_arg   = cmd_arg_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Bench for sdcard_cmd_responder: acts as SD host and card model, checking decoded commands
// and response frames against a polynomial-division CRC7 reference model.
module tb_sdcard_cmd_responder;

    localparam int NCR     = 2;
    localparam int SD_HALF = 80;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sdcard_cmd_responder_if bus();

    sdcard_cmd_responder #(.NCR(NCR), .SYNC_STG(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        bus.sd_clk = 1'b0;
        forever #SD_HALF bus.sd_clk = ~bus.sd_clk;
    end

    int checks   = 0;
    int failures = 0;

    // Host-side view of the CMD line: response bits and the SD cycle of each start bit.
    int   sd_cyc  = 0;
    bit   rsp_bits[$];
    int   rsp_start[$];
    logic oe_prev = 1'b0;

    always @(posedge bus.sd_clk) begin
        sd_cyc++;
        if (bus.cmd_oe) begin
            if (!oe_prev) rsp_start.push_back(sd_cyc);
            rsp_bits.push_back(bus.cmd_out);
        end
        oe_prev = bus.cmd_oe;
    end

    int   clk_cyc        = 0;
    int   valid_hi       = 0;
    int   err_hi         = 0;
    int   oe_hi          = 0;
    int   last_valid_cyc = 0;
    int   last_idle_cyc  = 0;
    logic busy_prev      = 1'b0;

    always @(negedge clk) begin
        clk_cyc++;
        if (bus.cmd_valid) begin
            valid_hi++;
            last_valid_cyc = clk_cyc;
        end
        if (bus.crc_err) err_hi++;
        if (bus.cmd_oe) oe_hi++;
        if (busy_prev && !bus.busy) last_idle_cyc = clk_cyc;
        busy_prev = bus.busy;
    end

    int v0, e0, o0, b0, s0;
    int end_idx;

    function automatic logic [6:0] refCrc7(input logic [39:0] d);
        logic [46:0] v;
        v = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] refFrame(input logic tx, input logic [5:0] idx,
                                             input logic [31:0] arg, input logic nocrc);
        return {1'b0, tx, idx, arg, nocrc ? 7'h7F : refCrc7({1'b0, tx, idx, arg}), 1'b1};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            @(negedge bus.sd_clk);
            bus.cmd_in = frame[i];
        end
        end_idx = sd_cyc + 1;
        @(negedge bus.sd_clk);
        bus.cmd_in = 1'b1;
    endtask

    task automatic setRsp(input logic valid, input logic none, input logic [5:0] idx,
                          input logic [31:0] arg, input logic nocrc);
        bus.rsp_valid = valid;
        bus.rsp_none  = none;
        bus.rsp_idx   = idx;
        bus.rsp_arg   = arg;
        bus.rsp_nocrc = nocrc;
    endtask

    task automatic snap();
        v0 = valid_hi;
        e0 = err_hi;
        o0 = oe_hi;
        b0 = rsp_bits.size();
        s0 = rsp_start.size();
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", bus.busy, 1'b0);
    endtask

    task automatic checkTxn(input string tag, input logic good, input logic expRsp,
                            input logic [47:0] rspFrame, input int expStart,
                            input logic [5:0] expIdx, input logic [31:0] expArg);
        logic [47:0] got;
        got = '0;
        checkOutput({tag, "_valid"}, valid_hi - v0, good ? 1 : 0);
        checkOutput({tag, "_crcerr"}, err_hi - e0, good ? 0 : 1);
        checkOutput({tag, "_idx"}, bus.cmd_idx, expIdx);
        checkOutput({tag, "_arg"}, bus.cmd_arg, expArg);
        if (expRsp) begin
            checkOutput({tag, "_rspbits"}, rsp_bits.size() - b0, 48);
            for (int k = 0; k < 48; k++) begin
                if (b0 + k < rsp_bits.size()) got = {got[46:0], rsp_bits[b0 + k]};
            end
            checkOutput({tag, "_rsp"}, got, rspFrame);
            checkOutput({tag, "_start"}, (rsp_start.size() > s0) ? rsp_start[s0] : -1, expStart);
        end else begin
            checkOutput({tag, "_no_oe"}, oe_hi - o0, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0]  exp_idx;
        logic [31:0] exp_arg;
        logic [47:0] frame;
        int          n;
        int          late_k;

        bus.cmd_in = 1'b1;
        setRsp(1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("rst_oe", bus.cmd_oe, 1'b0);
        checkOutput("rst_out", bus.cmd_out, 1'b1);
        checkOutput("rst_valid", bus.cmd_valid, 1'b0);
        checkOutput("rst_crcerr", bus.crc_err, 1'b0);
        checkOutput("rst_idx", bus.cmd_idx, 6'd0);
        checkOutput("rst_arg", bus.cmd_arg, 32'd0);
        checkOutput("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // CMD0 with no response; BUSY must drop right after the valid pulse.
        setRsp(1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
        snap();
        applyStimulus(48'h400000000095);
        waitIdle();
        checkTxn("cmd0", 1'b1, 1'b0, '0, 0, 6'd0, 32'd0);
        checkOutput("cmd0_busy_drop",
                    ((last_idle_cyc - last_valid_cyc) >= 1) && ((last_idle_cyc - last_valid_cyc) <= 2), 1'b1);

        setRsp(1'b1, 1'b0, 6'd8, 32'h1AA, 1'b0);
        snap();
        applyStimulus(48'h48000001AA87);
        waitIdle();
        checkTxn("cmd8", 1'b1, 1'b1, 48'h08000001AA13, end_idx + NCR, 6'd8, 32'h1AA);

        setRsp(1'b1, 1'b0, 6'd17, 32'h0, 1'b0);
        snap();
        applyStimulus(48'h510000000057);
        waitIdle();
        checkTxn("cmd17_badcrc", 1'b0, 1'b0, '0, 0, 6'd8, 32'h1AA);

        setRsp(1'b1, 1'b0, 6'h3F, 32'h80FF8000, 1'b1);
        snap();
        applyStimulus(refFrame(1'b1, 6'd58, 32'h0, 1'b0));
        waitIdle();
        checkTxn("r3", 1'b1, 1'b1, 48'h3F80FF8000FF, end_idx + NCR, 6'd58, 32'h0);

        // Reset in the middle of a response, then a clean CMD0.
        setRsp(1'b1, 1'b0, 6'd8, 32'h1AA, 1'b0);
        snap();
        applyStimulus(48'h48000001AA87);
        n = 0;
        while ((rsp_bits.size() < b0 + 20) && n < 400) begin
            @(negedge bus.sd_clk);
            n++;
        end
        checkOutput("midtx_reached", rsp_bits.size() >= b0 + 20, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midtx_oe", bus.cmd_oe, 1'b0);
        checkOutput("midtx_out", bus.cmd_out, 1'b1);
        checkOutput("midtx_busy", bus.busy, 1'b0);
        checkOutput("midtx_idx", bus.cmd_idx, 6'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        setRsp(1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
        snap();
        applyStimulus(48'h400000000095);
        waitIdle();
        checkTxn("cmd0_after_reset", 1'b1, 1'b0, '0, 0, 6'd0, 32'd0);

        // Late card model: response starts on the first drive strobe after RSP_VALID.
        setRsp(1'b0, 1'b0, 6'd8, 32'h1AA, 1'b0);
        snap();
        applyStimulus(48'h48000001AA87);
        repeat (10) @(posedge bus.sd_clk);
        #20;
        late_k = sd_cyc;
        checkOutput("late_no_early_oe", oe_hi - o0, 0);
        bus.rsp_valid = 1'b1;
        waitIdle();
        bus.rsp_valid = 1'b0;
        checkTxn("late", 1'b1, 1'b1, 48'h08000001AA13, late_k + 1, 6'd8, 32'h1AA);

        setRsp(1'b1, 1'b1, 6'd8, 32'h1AA, 1'b0);
        snap();
        applyStimulus(48'h48000001AA87);
        waitIdle();
        checkTxn("none_wins", 1'b1, 1'b0, '0, 0, 6'd8, 32'h1AA);

        exp_idx = 6'd8;
        exp_arg = 32'h1AA;
        for (int it = 0; it < 10; it++) begin
            logic [5:0]  idx;
            logic [31:0] arg;
            logic        corrupt;
            int          mode;
            int          pos;
            logic [5:0]  ridx;
            logic [31:0] rarg;
            idx     = 6'($urandom_range(0, 63));
            arg     = $urandom;
            frame   = refFrame(1'b1, idx, arg, 1'b0);
            corrupt = ($urandom_range(0, 3) == 0);
            if (corrupt) begin
                pos = $urandom_range(0, 8);
                pos = (pos == 0) ? 46 : (pos == 1) ? 0 : pos - 1;
                frame[pos] = ~frame[pos];
            end
            mode = $urandom_range(0, 2);
            ridx = (mode == 2) ? 6'h3F : idx;
            rarg = $urandom;
            setRsp((mode != 0) ? 1'b1 : 1'($urandom_range(0, 1)), mode == 0, ridx, rarg, mode == 2);
            if (!corrupt) begin
                exp_idx = idx;
                exp_arg = arg;
            end
            snap();
            applyStimulus(frame);
            waitIdle();
            checkTxn($sformatf("rand%0d", it), !corrupt, !corrupt && (mode != 0),
                     refFrame(1'b0, ridx, rarg, mode == 2), end_idx + NCR, exp_idx, exp_arg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
